// File: rtl/rom_download_ctrl_if.sv
// Loader/SDRAM-side signal bundle for rom_download_ctrl.
// The master modport is the controller: it consumes the ioctl byte stream
// and the SDRAM ack, and drives the SDRAM write request and the status flags.
interface rom_download_ctrl_if #(
  parameter int unsigned ADDR_WIDTH       = 20,
  parameter int unsigned SDRAM_ADDR_WIDTH = 23
);
  logic [ADDR_WIDTH-1:0]       ioctl_addr;
  logic [7:0]                  ioctl_data;
  logic                        ioctl_wr;
  logic                        ioctl_download;
  logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr;
  logic [31:0]                 sdram_data;
  logic                        sdram_we;
  logic                        sdram_req;
  logic                        sdram_ack;
  logic                        busy;
  logic                        done;
  logic                        overflow;

  modport master (
    input  ioctl_addr, ioctl_data, ioctl_wr, ioctl_download, sdram_ack,
    output sdram_addr, sdram_data, sdram_we, sdram_req, busy, done, overflow
  );

  modport slave (
    output ioctl_addr, ioctl_data, ioctl_wr, ioctl_download, sdram_ack,
    input  sdram_addr, sdram_data, sdram_we, sdram_req, busy, done, overflow
  );
endinterface

// File: rtl/rom_download_ctrl.sv
// ROM download packer: assembles the byte-wide HPS download stream into
// 32-bit little-endian words and writes them to SDRAM over a req/ack port.
// Two stages: ASM collects bytes of one word, PEND holds the word on the bus.
module rom_download_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 20,
  parameter int unsigned SDRAM_ADDR_WIDTH = 23,
  parameter int unsigned BASE_ADDR        = 0,
  parameter logic [7:0]  FILL             = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  rom_download_ctrl_if.master bus
);

  typedef logic [SDRAM_ADDR_WIDTH-1:0] waddr_t;

  // Complete buffer state; a_mask stays 4'hF while a_full is set.
  typedef struct packed {
    logic [31:0] a_data;
    waddr_t      a_addr;
    logic [3:0]  a_mask;
    logic        a_full;
    logic        p_valid;
    waddr_t      p_addr;
    logic [31:0] p_data;
  } buf_t;

  buf_t   cur, nxt;
  logic   dl_q, overflow_q, seen, done_q;
  logic   ovf_n, seen_n, done_n;
  logic   dl_rise, dl_fall;
  logic   [1:0] lane;
  waddr_t byte_waddr;

  // Close the ASM word: pad missing lanes, then hand it to PEND if that
  // slot is free, otherwise park it in ASM as a full word.
  function automatic buf_t close_word(input buf_t s);
    buf_t r;
    r = s;
    for (int k = 0; k < 4; k++)
      if (!s.a_mask[k]) r.a_data[8*k +: 8] = FILL;
    if (!s.p_valid) begin
      r.p_valid = 1'b1;
      r.p_addr  = s.a_addr;
      r.p_data  = r.a_data;
      r.a_mask  = '0;
      r.a_full  = 1'b0;
    end else begin
      r.a_mask  = 4'hF;
      r.a_full  = 1'b1;
    end
    return r;
  endfunction

  assign dl_rise    = bus.ioctl_download & ~dl_q;
  assign dl_fall    = ~bus.ioctl_download & dl_q;
  assign lane       = bus.ioctl_addr[1:0];
  // Word address wraps silently modulo 2^SDRAM_ADDR_WIDTH.
  assign byte_waddr = waddr_t'(BASE_ADDR) + waddr_t'(bus.ioctl_addr[ADDR_WIDTH-1:2]);

  // Next-state: ack transfer first, then download rise, byte accept, flush on fall.
  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    nxt    = cur;
    ovf_n  = overflow_q;
    seen_n = seen;
    done_n = 1'b0;

    if (bus.sdram_ack && cur.p_valid) begin
      nxt.p_valid = 1'b0;
      if (cur.a_full) begin
        nxt.p_valid = 1'b1;
        nxt.p_addr  = cur.a_addr;
        nxt.p_data  = cur.a_data;
        nxt.a_mask  = '0;
        nxt.a_full  = 1'b0;
      end
    end

    if (dl_rise) begin
      ovf_n  = 1'b0;
      seen_n = 1'b1;
      if (!nxt.a_full) nxt.a_mask = '0;
    end

    if (bus.ioctl_wr) begin
      if (!nxt.a_full && nxt.a_mask != '0 && byte_waddr != nxt.a_addr)
        nxt = close_word(nxt);
      if (nxt.a_full) begin
        ovf_n = 1'b1;
      end else begin
        if (nxt.a_mask == '0) nxt.a_addr = byte_waddr;
        nxt.a_data[{lane, 3'b000} +: 8] = bus.ioctl_data;
        nxt.a_mask[lane] = 1'b1;
        if (nxt.a_mask == 4'hF) nxt = close_word(nxt);
      end
    end

    if (dl_fall && nxt.a_mask != '0 && !nxt.a_full)
      nxt = close_word(nxt);

    if (!bus.ioctl_download && !cur.p_valid && cur.a_mask == '0 && seen) begin
      done_n = 1'b1;
      seen_n = 1'b0;
    end
  end

  // State register; reset drops the request immediately and discards buffered data.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      dl_q       <= 1'b0;
      overflow_q <= 1'b0;
      seen       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cur        <= nxt;
      dl_q       <= bus.ioctl_download;
      overflow_q <= ovf_n;
      seen       <= seen_n;
      done_q     <= done_n;
    end
  end

  assign bus.sdram_req  = cur.p_valid;
  assign bus.sdram_we   = cur.p_valid;
  assign bus.sdram_addr = cur.p_addr;
  assign bus.sdram_data = cur.p_data;
  assign bus.busy       = bus.ioctl_download | cur.p_valid | (cur.a_mask != '0);
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed testbench for rom_download_ctrl: one DUT with BASE_ADDR=0/FILL=0
// driven through a small SDRAM responder, and one with BASE_ADDR=0x100000/
// FILL=0xEE acked by hand.
module tb_rom_download_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rom_download_ctrl_if #(.ADDR_WIDTH(20), .SDRAM_ADDR_WIDTH(23)) bus0 ();
  rom_download_ctrl_if #(.ADDR_WIDTH(20), .SDRAM_ADDR_WIDTH(23)) bus1 ();

  rom_download_ctrl #(.ADDR_WIDTH(20), .SDRAM_ADDR_WIDTH(23), .BASE_ADDR(0), .FILL(8'h00))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  rom_download_ctrl #(.ADDR_WIDTH(20), .SDRAM_ADDR_WIDTH(23), .BASE_ADDR(32'h100000), .FILL(8'hEE))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  bit          ack_en    = 1'b0;
  int          ack_delay = 2;
  int          wait_cnt  = 0;
  logic [22:0] log_addr[$];
  logic [31:0] log_data[$];
  int          done0_cnt = 0;
  int          done1_cnt = 0;

  // Count done pulses once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus0.done === 1'b1) done0_cnt++;
    if (bus1.done === 1'b1) done1_cnt++;
  end

  // SDRAM responder for dut0: acks a held request after ack_delay+1 cycles
  // and logs the word it accepts.
  initial begin
    bus0.sdram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus0.sdram_ack) begin
        bus0.sdram_ack = 1'b0;
      end else if (ack_en && bus0.sdram_req === 1'b1 && !reset) begin
        if (wait_cnt >= ack_delay) begin
          bus0.sdram_ack = 1'b1;
          log_addr.push_back(bus0.sdram_addr);
          log_data.push_back(bus0.sdram_data);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic send_byte0(input logic [19:0] a, input logic [7:0] d);
    @(negedge clk);
    bus0.ioctl_addr = a;
    bus0.ioctl_data = d;
    bus0.ioctl_wr   = 1'b1;
    @(negedge clk);
    bus0.ioctl_wr   = 1'b0;
  endtask

  task automatic send_byte1(input logic [19:0] a, input logic [7:0] d);
    @(negedge clk);
    bus1.ioctl_addr = a;
    bus1.ioctl_data = d;
    bus1.ioctl_wr   = 1'b1;
    @(negedge clk);
    bus1.ioctl_wr   = 1'b0;
  endtask

  task automatic set_dl0(input logic v);
    @(negedge clk);
    bus0.ioctl_download = v;
  endtask

  // Waits (bounded) for a new done pulse on dut0, then lets things settle.
  task automatic wait_done0(input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus0.sdram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", bus0.sdram_req); end
    n_checks++; if (bus0.sdram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus0.sdram_we); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
    n_checks++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
    n_checks++; if (bus0.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", bus0.overflow); end
    n_checks++; if (bus0.sdram_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus0.sdram_data); end
    n_checks++; if (bus1.sdram_addr !== 23'h0) begin n_fail++; $display("FAIL reset_addr1 got=%h exp=0", bus1.sdram_addr); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sequential();
    int d0;
    bit ok;
    clear_log();
    ack_en = 1'b1;
    d0 = done0_cnt;
    set_dl0(1'b1);
    for (int i = 0; i < 8; i++) send_byte0(20'(i), 8'h11 + 8'(i));
    set_dl0(1'b0);
    wait_done0(d0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_done_timeout got=no_done exp=done"); end
    n_checks++; if (log_addr.size() != 2) begin n_fail++; $display("FAIL seq_count got=%0d exp=2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      n_checks++; if (log_addr[0] !== 23'h0) begin n_fail++; $display("FAIL seq_addr0 got=%h exp=0", log_addr[0]); end
      n_checks++; if (log_data[0] !== 32'h14131211) begin n_fail++; $display("FAIL seq_data0 got=%h exp=14131211", log_data[0]); end
      n_checks++; if (log_addr[1] !== 23'h1) begin n_fail++; $display("FAIL seq_addr1 got=%h exp=1", log_addr[1]); end
      n_checks++; if (log_data[1] !== 32'h18171615) begin n_fail++; $display("FAIL seq_data1 got=%h exp=18171615", log_data[1]); end
    end
    n_checks++; if (done0_cnt - d0 != 1) begin n_fail++; $display("FAIL seq_done_pulses got=%0d exp=1", done0_cnt - d0); end
    n_checks++; if (bus0.overflow !== 1'b0) begin n_fail++; $display("FAIL seq_overflow got=%b exp=0", bus0.overflow); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy_idle got=%b exp=0", bus0.busy); end
  endtask

  task automatic test_partial_flush();
    int d0;
    bit ok;
    clear_log();
    ack_en = 1'b1;
    d0 = done0_cnt;
    set_dl0(1'b1);
    for (int i = 0; i < 6; i++) send_byte0(20'(i), 8'hA0 + 8'(i));
    set_dl0(1'b0);
    wait_done0(d0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_done_timeout got=no_done exp=done"); end
    n_checks++; if (log_addr.size() != 2) begin n_fail++; $display("FAIL flush_count got=%0d exp=2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      n_checks++; if (log_data[0] !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL flush_data0 got=%h exp=A3A2A1A0", log_data[0]); end
      n_checks++; if (log_addr[1] !== 23'h1) begin n_fail++; $display("FAIL flush_addr1 got=%h exp=1", log_addr[1]); end
      n_checks++; if (log_data[1] !== 32'h0000A5A4) begin n_fail++; $display("FAIL flush_data1 got=%h exp=0000A5A4", log_data[1]); end
    end
    n_checks++; if (done0_cnt - d0 != 1) begin n_fail++; $display("FAIL flush_done_pulses got=%0d exp=1", done0_cnt - d0); end
  endtask

  task automatic test_overflow();
    int d0;
    int gaps;
    bit ok;
    clear_log();
    ack_en = 1'b0;
    d0 = done0_cnt;
    set_dl0(1'b1);
    for (int i = 0; i < 12; i++) send_byte0(20'(i), 8'h20 + 8'(i));
    n_checks++; if (bus0.sdram_req !== 1'b1) begin n_fail++; $display("FAIL ovf_req_held got=%b exp=1", bus0.sdram_req); end
    n_checks++; if (bus0.sdram_data !== 32'h23222120) begin n_fail++; $display("FAIL ovf_pend_data got=%h exp=23222120", bus0.sdram_data); end
    n_checks++; if (bus0.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", bus0.overflow); end
    ack_en = 1'b1;
    gaps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (log_addr.size() >= 2) break;
      if (bus0.sdram_req !== 1'b1) gaps++;
    end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL ovf_req_gap got=%0d exp=0", gaps); end
    repeat (4) @(negedge clk);
    n_checks++; if (bus0.sdram_req !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped_word got=%b exp=0", bus0.sdram_req); end
    n_checks++; if (log_addr.size() != 2) begin n_fail++; $display("FAIL ovf_count got=%0d exp=2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      n_checks++; if (log_addr[1] !== 23'h1) begin n_fail++; $display("FAIL ovf_addr1 got=%h exp=1", log_addr[1]); end
      n_checks++; if (log_data[1] !== 32'h27262524) begin n_fail++; $display("FAIL ovf_data1 got=%h exp=27262524", log_data[1]); end
    end
    set_dl0(1'b0);
    wait_done0(d0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_done_timeout got=no_done exp=done"); end
    n_checks++; if (bus0.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bus0.overflow); end
    set_dl0(1'b1);
    @(negedge clk);
    n_checks++; if (bus0.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_on_rise got=%b exp=0", bus0.overflow); end
    d0 = done0_cnt;
    set_dl0(1'b0);
    wait_done0(d0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_empty_done got=no_done exp=done"); end
  endtask

  task automatic test_addr_jump();
    int d0;
    bit ok;
    clear_log();
    ack_en = 1'b1;
    d0 = done0_cnt;
    set_dl0(1'b1);
    send_byte0(20'h000, 8'h11);
    send_byte0(20'h001, 8'h22);
    send_byte0(20'h100, 8'h33);
    n_checks++; if (bus0.sdram_req !== 1'b1) begin n_fail++; $display("FAIL jump_req got=%b exp=1", bus0.sdram_req); end
    n_checks++; if (bus0.sdram_addr !== 23'h0) begin n_fail++; $display("FAIL jump_addr got=%h exp=0", bus0.sdram_addr); end
    n_checks++; if (bus0.sdram_data !== 32'h00002211) begin n_fail++; $display("FAIL jump_data got=%h exp=00002211", bus0.sdram_data); end
    set_dl0(1'b0);
    wait_done0(d0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL jump_done_timeout got=no_done exp=done"); end
    n_checks++; if (log_addr.size() != 2) begin n_fail++; $display("FAIL jump_count got=%0d exp=2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      n_checks++; if (log_addr[1] !== 23'h40) begin n_fail++; $display("FAIL jump_addr1 got=%h exp=40", log_addr[1]); end
      n_checks++; if (log_data[1] !== 32'h00000033) begin n_fail++; $display("FAIL jump_data1 got=%h exp=00000033", log_data[1]); end
    end
  endtask

  task automatic test_base_addr();
    int d1;
    bit ok;
    d1 = done1_cnt;
    @(negedge clk);
    bus1.ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) send_byte1(20'h3FFFC + 20'(i), 8'h01 + 8'(i));
    n_checks++; if (bus1.sdram_req !== 1'b1) begin n_fail++; $display("FAIL base_req got=%b exp=1", bus1.sdram_req); end
    n_checks++; if (bus1.sdram_we !== 1'b1) begin n_fail++; $display("FAIL base_we got=%b exp=1", bus1.sdram_we); end
    n_checks++; if (bus1.sdram_addr !== 23'h10FFFF) begin n_fail++; $display("FAIL base_addr got=%h exp=10FFFF", bus1.sdram_addr); end
    n_checks++; if (bus1.sdram_data !== 32'h04030201) begin n_fail++; $display("FAIL base_data got=%h exp=04030201", bus1.sdram_data); end
    @(negedge clk); bus1.sdram_ack = 1'b1;
    @(negedge clk); bus1.sdram_ack = 1'b0;
    n_checks++; if (bus1.sdram_req !== 1'b0) begin n_fail++; $display("FAIL base_req_after_ack got=%b exp=0", bus1.sdram_req); end
    send_byte1(20'h00002, 8'h55);
    @(negedge clk); bus1.ioctl_download = 1'b0;
    @(negedge clk);
    n_checks++; if (bus1.sdram_addr !== 23'h100000) begin n_fail++; $display("FAIL base_fill_addr got=%h exp=100000", bus1.sdram_addr); end
    n_checks++; if (bus1.sdram_data !== 32'hEE55EEEE) begin n_fail++; $display("FAIL base_fill_data got=%h exp=EE55EEEE", bus1.sdram_data); end
    bus1.sdram_ack = 1'b1;
    @(negedge clk); bus1.sdram_ack = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1_cnt > d1) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    n_checks++; if (!ok || done1_cnt - d1 != 1) begin n_fail++; $display("FAIL base_done_pulses got=%0d exp=1", done1_cnt - d1); end
  endtask

  task automatic test_reset_mid_request();
    int d0;
    bit ok;
    clear_log();
    ack_en = 1'b0;
    set_dl0(1'b1);
    for (int i = 0; i < 4; i++) send_byte0(20'(i), 8'h30 + 8'(i));
    n_checks++; if (bus0.sdram_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req got=%b exp=1", bus0.sdram_req); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus0.ioctl_download = 1'b0;
    #1;
    n_checks++; if (bus0.sdram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", bus0.sdram_req); end
    n_checks++; if (bus0.sdram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b exp=0", bus0.sdram_we); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus0.busy); end
    n_checks++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", bus0.done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
    ack_en = 1'b1;
    d0 = done0_cnt;
    set_dl0(1'b1);
    for (int i = 0; i < 4; i++) send_byte0(20'h4 + 20'(i), 8'h41 + 8'(i));
    set_dl0(1'b0);
    wait_done0(d0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_new_done_timeout got=no_done exp=done"); end
    n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL rst_new_count got=%0d exp=1", log_addr.size()); end
    if (log_addr.size() >= 1) begin
      n_checks++; if (log_addr[0] !== 23'h1) begin n_fail++; $display("FAIL rst_new_addr got=%h exp=1", log_addr[0]); end
      n_checks++; if (log_data[0] !== 32'h44434241) begin n_fail++; $display("FAIL rst_new_data got=%h exp=44434241", log_data[0]); end
    end
    n_checks++; if (done0_cnt - d0 != 1) begin n_fail++; $display("FAIL rst_new_done_pulses got=%0d exp=1", done0_cnt - d0); end
  endtask

  initial begin
    reset = 1'b1;
    bus0.ioctl_addr = '0; bus0.ioctl_data = '0; bus0.ioctl_wr = 1'b0; bus0.ioctl_download = 1'b0;
    bus1.ioctl_addr = '0; bus1.ioctl_data = '0; bus1.ioctl_wr = 1'b0; bus1.ioctl_download = 1'b0;
    bus1.sdram_ack  = 1'b0;
    test_reset();
    test_sequential();
    test_partial_flush();
    test_overflow();
    test_addr_jump();
    test_base_addr();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/rom_download_ctrl.md
Name: rom_download_ctrl

Overview:
Packs the byte-wide ROM download stream from the HPS loader into 32-bit little-endian words and writes them to the SDRAM controller through its req/ack port. Sits between the hps_io ioctl signals and the game core's SDRAM write path. Provides a two-stage word buffer, flushes partial words and reports completion and overflow.

Parameters:
ADDR_WIDTH, 20, width of ioctl_addr (byte address)
SDRAM_ADDR_WIDTH, 23, width of sdram_addr (32-bit word address)
BASE_ADDR, 0, word offset added to every computed word address
FILL, 8'h00, value written to byte lanes not supplied in a flushed partial word

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ioctl_addr  in  ADDR_WIDTH  byte address of the current download byte
ioctl_data  in  8  download byte
ioctl_wr  in  1  one-cycle strobe: byte valid
ioctl_download  in  1  high for the whole download
sdram_addr  out  SDRAM_ADDR_WIDTH  word address = BASE_ADDR + ioctl_addr[ADDR_WIDTH-1:2]
sdram_data  out  32  word; byte k at bits [8k+7:8k], k = ioctl_addr[1:0]
sdram_we  out  1  high whenever sdram_req is high
sdram_req  out  1  write request, held until ack
sdram_ack  in  1  one-cycle accept from SDRAM controller
busy  out  1  download high, or any buffered word present
done  out  1  one-cycle pulse when a download has fully drained
overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset (async): all outputs 0; ASM and PEND empty; lane mask 0; download-seen flag 0.
- Two stages. ASM assembles the word: data, word address, 4-bit lane mask, full flag. PEND drives sdram_addr/data; PEND valid == sdram_req == sdram_we.
- ioctl_wr while ASM is not full:
  - If the lane mask is nonzero and the byte's word address differs from the ASM address, close the current word first. Missing lanes take FILL, then the word moves to PEND or ASM becomes full.
  - The byte then starts a new ASM word. Its lane is written and the mask bit set.
- Word complete (mask becomes 4'hF) or closed:
  - If PEND is empty, or is emptied by sdram_ack in the same cycle, the word loads PEND on that edge. sdram_req is high from the next cycle.
  - Otherwise ASM holds the word with its full flag set.
- sdram_ack sampled high with PEND valid: PEND clears on that edge. If ASM is full on the same edge, its word loads PEND, req stays high and the address/data update. No idle cycle.
- ioctl_wr while ASM is full and no transfer happens on that edge: the byte is dropped and overflow is set.
- sdram_req never deasserts without ack, except on reset. Addr/data are stable while req is high. ack while req is low is ignored.
- Falling edge of ioctl_download: a partial ASM word (mask nonzero, not full) is closed with FILL lanes. A byte whose ioctl_wr coincides with the fall is accepted first, then the flush applies.
- Rising edge of ioctl_download: clears overflow, sets the download-seen flag, discards an unstarted ASM mask. PEND is not disturbed.
- done pulses for exactly one cycle when all of these hold: download low, ASM empty, PEND empty, download-seen flag set. The flag clears with the pulse.
- busy = ioctl_download | PEND valid | (ASM mask != 0).
- Address arithmetic is modulo 2^SDRAM_ADDR_WIDTH; wrap is silent.
- Reset mid-request: req drops asynchronously and the buffered data is lost.

Test Plan:
- Sequential download of 8 bytes at addr 0..7 = 11..18, ack 3 cycles after each req, BASE_ADDR=0 -> write 0x14131211 @0, then 0x18171615 @1; done pulses once after the second ack; overflow=0.
- 6 bytes 0xA0..0xA5 then download falls -> write 0xA3A2A1A0 @0, then 0x0000A5A4 @1 (FILL=0); done follows the second ack.
- Ack withheld; 12 consecutive bytes arrive -> word0 in PEND, word1 held in ASM, bytes 9..12 dropped, overflow=1. Ack then returns -> word1 issued with req continuous, no gap. overflow clears at the next download rise.
- Address jump: bytes at 0x000,0x001 then 0x100 -> write 0x0000xxyy @0 issued before the 0x100 word starts; final flush gives @0x40.
- BASE_ADDR=0x100000, byte addr 0x3FFFC..F -> sdram_addr 0x10FFFF.
- Reset asserted while req=1 -> req, we, busy and done go 0 immediately. A new download then starts from an empty state.
